// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, 2-entry return FIFO, redirect flush.
// Optional halt-sequence detection is compiled in with FETCH_HALT_DETECT_EN.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              I_MEM_REQ,
  output logic [ADDR_W-1:0] I_MEM_ADDR,
  input  logic [31:0]       I_MEM_DI,
  output logic [31:0]       INSTR,
  output logic [31:0]       INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  input  logic              REDIRECT,
  input  logic [31:0]       REDIRECT_PC,
  output logic              HALT
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] tag_pc_q, tag_pc_d;
  logic        in_flight_q, in_flight_d;
  logic [1:0]  occ_q, occ_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_instr_d [2];
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic        halt;
  logic        head_valid;
  logic        instr_valid;
  logic        pop;
  logic        push;
  logic        req;
  logic [2:0]  credit;
  logic [31:0] head_pc;
  logic [31:0] head_instr;

  assign head_valid = (occ_q != 2'd0);
  assign head_pc    = fifo_pc_q[rd_ptr_q];
  assign head_instr = fifo_instr_q[rd_ptr_q];

  always_comb begin
    instr_valid = head_valid & ~REDIRECT & ~halt;
    pop         = instr_valid & INSTR_READY;
    // Slots already claimed (buffered + in flight), net of this cycle's pop.
    credit      = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
    req         = ~RST & ~REDIRECT & ~halt & (credit < 3'd2);
    // Frozen while halted; a late response is discarded.
    push        = in_flight_q & ~REDIRECT & ~halt;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    tag_pc_d     = tag_pc_q;
    in_flight_d  = req;
    occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d     = rd_ptr_q ^ pop;
    wr_ptr_d     = wr_ptr_q ^ push;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    hold_pc_d    = head_valid ? head_pc : hold_pc_q;
    hold_instr_d = head_valid ? head_instr : hold_instr_q;

    if (push) begin
      fifo_pc_d[wr_ptr_q]    = tag_pc_q;
      fifo_instr_d[wr_ptr_q] = I_MEM_DI;
    end
    if (req) begin
      tag_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (REDIRECT) begin
      occ_d      = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      fetch_pc_d = REDIRECT_PC & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q   <= RESET_PC;
      tag_pc_q     <= 32'd0;
      in_flight_q  <= 1'b0;
      occ_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tag_pc_q     <= tag_pc_d;
      in_flight_q  <= in_flight_d;
      occ_q        <= occ_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge CLK) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halt_q, halt_d;
  logic pair_q, pair_d;

  // pair_q: last popped word was the first half of the halt sequence.
  always_comb begin
    halt_d = halt_q;
    pair_d = pair_q;
    if (REDIRECT) begin
      pair_d = 1'b0;
    end else if (pop) begin
      if (pair_q && (head_instr == 32'h0000_8067)) halt_d = 1'b1;
      pair_d = (head_instr == 32'h00c0_0093);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q <= 1'b0;
      pair_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      pair_q <= pair_d;
    end
  end

  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign I_MEM_REQ   = req;
  assign I_MEM_ADDR  = fetch_pc_q[ADDR_W-1:0];
  assign INSTR_VALID = instr_valid;
  assign INSTR       = head_valid ? head_instr : hold_instr_q;
  assign INSTR_PC    = head_valid ? head_pc : hold_pc_q;
  assign HALT        = halt;

endmodule
